// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall/flush control blocks.
//   state_t  : stall-controller FSM encoding (RUN, WAIT, ERR)
//   REG_ZERO : architectural $zero register index, never a real dependency
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: purely combinational load-use hazard compare.
// Ports:
//   id_rs, id_rt  : source register fields of the instruction in ID
//   id_uses_rt    : ID instruction actually reads rt
//   ex_mem_read   : instruction in EX is a load
//   ex_rd         : destination register of the EX instruction
//   hazard        : ID needs the load result before it exists
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rd == id_rs);
  // rt only counts when the ID instruction really sources it (e.g. not for I-type dest)
  assign rt_match = id_uses_rt && (ex_rd == id_rt);
  // A load into $zero produces nothing to wait for
  assign hazard   = ex_mem_read && (ex_rd != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// Ports:
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd : load-use hazard inputs
//   ex_branch_taken, id_jump                      : control-flow redirects
//   mem_access, dmem_ready                        : data-memory handshake
//   pc_we, ifid_we, idex_we, exmem_we             : stage register write enables
//   ifid_flush, idex_flush, memwb_bubble          : NOP / bubble insertion
//   dmem_req                                      : data-memory request
//   stall_cnt                                     : saturating count of cycles with pc_we=0
//   timeout_err                                   : sticky memory-timeout flag
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  state_t            state_reg;
  logic [TO_W-1:0]   wait_cnt_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              timeout_err_reg;

  logic hazard;
  logic mem_active;
  logic mem_busy;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign mem_active = (state_reg == RUN) || (state_reg == WAIT);
  assign mem_busy   = mem_active && mem_access && !dmem_ready;

  // Output priority mux. Reset is folded in so that dropping reset
  // mid-access kills dmem_req without waiting for a clock edge.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = mem_active && mem_access;
    if (!reset) begin
      dmem_req = 1'b0;
    end else if (state_reg == ERR || mem_busy) begin
      // whole pipeline frozen; MEM/WB keeps retiring nothing
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // wrong-path instructions in IF and ID are squashed, so any
      // load-use or jump seen in ID is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      // hold PC and IF/ID, send a bubble down behind the load
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      stall_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (!pc_we && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      case (state_reg)
        RUN: begin
          if (mem_busy) begin
            state_reg    <= WAIT;
            wait_cnt_reg <= TO_W'(1);
          end
        end
        WAIT: begin
          if (!mem_access || dmem_ready) begin
            // completion, or requester gave up: either way resume
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == TIMEOUT_VAL) begin
            state_reg       <= ERR;
            timeout_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign stall_cnt   = stall_cnt_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       id_jump;
  logic       mem_access;
  logic       dmem_ready;
  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_we;
  logic       idex_flush;
  logic       exmem_we;
  logic       memwb_bubble;
  logic       dmem_req;
  logic [3:0] stall_cnt;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (4),
    .TO_W        (8),
    .CNT_W       (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .id_jump         (id_jump),
    .mem_access      (mem_access),
    .dmem_ready      (dmem_ready),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_we         (idex_we),
    .idex_flush      (idex_flush),
    .exmem_we        (exmem_we),
    .memwb_bubble    (memwb_bubble),
    .dmem_req        (dmem_req),
    .stall_cnt       (stall_cnt),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr_inputs();
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clr_inputs();
    mem_access = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    tick();
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_dmem_req got=%b want=0", dmem_req); end
    n_cmp++; if ({pc_we, ifid_we, idex_we, exmem_we} !== 4'b1111) begin n_err++; $display("FAIL rst_we got=%b want=1111", {pc_we, ifid_we, idex_we, exmem_we}); end
    n_cmp++; if ({ifid_flush, idex_flush, memwb_bubble} !== 3'b000) begin n_err++; $display("FAIL rst_flush got=%b want=000", {ifid_flush, idex_flush, memwb_bubble}); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall_cnt got=%0d want=0", stall_cnt); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout got=%b want=0", timeout_err); end
    $display("txn reset: pc_we=%b dmem_req=%b stall_cnt=%0d", pc_we, dmem_req, stall_cnt);
    reset = 1'b1;
    clr_inputs();
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    n_cmp++; if ({pc_we, ifid_we, idex_flush, exmem_we, ifid_flush} !== 5'b00110) begin n_err++; $display("FAIL lu_rs_ctrl got=%b want=00110", {pc_we, ifid_we, idex_flush, exmem_we, ifid_flush}); end
    $display("txn load_use rs: pc_we=%b ifid_we=%b idex_flush=%b", pc_we, ifid_we, idex_flush);
    tick();
    clr_inputs();
    #1;
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt1 got=%0d want=1", stall_cnt); end
    n_cmp++; if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin n_err++; $display("FAIL lu_one_cycle got=%b want=110", {pc_we, ifid_we, idex_flush}); end
    // rt dependency, rt actually used
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1;
    n_cmp++; if ({pc_we, ifid_we, idex_flush} !== 3'b001) begin n_err++; $display("FAIL lu_rt_ctrl got=%b want=001", {pc_we, ifid_we, idex_flush}); end
    $display("txn load_use rt: pc_we=%b", pc_we);
    tick();
    n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL lu_cnt2 got=%0d want=2", stall_cnt); end
    clr_inputs();
    #1;
  endtask

  task automatic test_no_stall();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    n_cmp++; if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin n_err++; $display("FAIL zero_rd got=%b want=110", {pc_we, ifid_we, idex_flush}); end
    $display("txn zero_rd: pc_we=%b", pc_we);
    tick();
    ex_rd = 5'd7; id_rs = 5'd2; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1;
    n_cmp++; if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin n_err++; $display("FAIL rt_unused got=%b want=110", {pc_we, ifid_we, idex_flush}); end
    $display("txn rt_unused: pc_we=%b", pc_we);
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd4; id_rs = 5'd4;
    #1;
    n_cmp++; if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin n_err++; $display("FAIL not_load got=%b want=110", {pc_we, ifid_we, idex_flush}); end
    $display("txn not_load: pc_we=%b", pc_we);
    tick();
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL no_stall_cnt got=%0d want=0", stall_cnt); end
    clr_inputs();
    #1;
  endtask

  task automatic test_branch_jump();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs = 5'd6; ex_branch_taken = 1'b1; id_jump = 1'b1;
    #1;
    n_cmp++; if ({pc_we, ifid_we, ifid_flush, idex_flush} !== 4'b1111) begin n_err++; $display("FAIL br_over_lu got=%b want=1111", {pc_we, ifid_we, ifid_flush, idex_flush}); end
    $display("txn branch+hazard: pc_we=%b ifid_flush=%b idex_flush=%b", pc_we, ifid_flush, idex_flush);
    tick();
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL br_cnt got=%0d want=0", stall_cnt); end
    clr_inputs();
    id_jump = 1'b1;
    #1;
    n_cmp++; if ({pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush} !== 6'b111110) begin n_err++; $display("FAIL jump got=%b want=111110", {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}); end
    $display("txn jump: ifid_flush=%b", ifid_flush);
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    #1;
    n_cmp++; if ({pc_we, ifid_flush, idex_flush} !== 3'b001) begin n_err++; $display("FAIL lu_over_jump got=%b want=001", {pc_we, ifid_flush, idex_flush}); end
    $display("txn jump+hazard: pc_we=%b", pc_we);
    tick();
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL jump_cnt got=%0d want=1", stall_cnt); end
    clr_inputs();
    #1;
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_bubble, ifid_flush} !== 7'b1000010) begin n_err++; $display("FAIL mw_busy[%0d] got=%b want=1000010", i, {dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_bubble, ifid_flush}); end
      $display("txn mem_wait cycle %0d: dmem_req=%b pc_we=%b", i, dmem_req, pc_we);
      tick();
    end
    ex_branch_taken = 1'b0;
    dmem_ready = 1'b1;
    #1;
    n_cmp++; if ({dmem_req, pc_we, exmem_we, memwb_bubble} !== 4'b1110) begin n_err++; $display("FAIL mw_ready got=%b want=1110", {dmem_req, pc_we, exmem_we, memwb_bubble}); end
    $display("txn mem_ready: dmem_req=%b pc_we=%b", dmem_req, pc_we);
    tick();
    n_cmp++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL mw_cnt got=%0d want=3", stall_cnt); end
    // back in RUN: a zero-wait access must not stall
    #1;
    n_cmp++; if ({dmem_req, pc_we, memwb_bubble} !== 3'b110) begin n_err++; $display("FAIL zero_wait got=%b want=110", {dmem_req, pc_we, memwb_bubble}); end
    tick();
    mem_access = 1'b0; dmem_ready = 1'b0;
    #1;
    n_cmp++; if ({dmem_req, pc_we, stall_cnt} !== {2'b01, 4'd3}) begin n_err++; $display("FAIL mw_idle got=%b want=01_0011", {dmem_req, pc_we, stall_cnt}); end
    clr_inputs();
    #1;
  endtask

  task automatic test_wait_edges();
    do_reset();
    // ready arrives exactly when the wait counter equals MEM_TIMEOUT
    mem_access = 1'b1; dmem_ready = 1'b0;
    repeat (4) tick();
    dmem_ready = 1'b1;
    #1;
    n_cmp++; if ({pc_we, timeout_err} !== 2'b10) begin n_err++; $display("FAIL edge_ready got=%b want=10", {pc_we, timeout_err}); end
    tick();
    n_cmp++; if ({timeout_err, stall_cnt} !== {1'b0, 4'd4}) begin n_err++; $display("FAIL edge_ready_after got=%b want=0_0100", {timeout_err, stall_cnt}); end
    $display("txn ready_at_limit: timeout_err=%b stall_cnt=%0d", timeout_err, stall_cnt);
    // requester withdraws mid-wait: back to RUN, counter cleared
    dmem_ready = 1'b0;
    repeat (3) tick();
    mem_access = 1'b0;
    #1;
    n_cmp++; if ({dmem_req, pc_we} !== 2'b01) begin n_err++; $display("FAIL withdraw got=%b want=01", {dmem_req, pc_we}); end
    tick();
    mem_access = 1'b1;
    repeat (4) tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL withdraw_cleared got=%b want=0", timeout_err); end
    $display("txn withdraw: timeout_err=%b", timeout_err);
    // asynchronous reset mid-WAIT drops the request immediately
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if ({dmem_req, pc_we, stall_cnt} !== {2'b01, 4'd0}) begin n_err++; $display("FAIL rst_mid_wait got=%b want=01_0000", {dmem_req, pc_we, stall_cnt}); end
    $display("txn reset_mid_wait: dmem_req=%b", dmem_req);
    tick();
    reset = 1'b1;
    clr_inputs();
    #1;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if ({timeout_err, dmem_req} !== 2'b01) begin n_err++; $display("FAIL to_pre[%0d] got=%b want=01", i, {timeout_err, dmem_req}); end
    end
    tick();
    n_cmp++; if ({timeout_err, dmem_req, pc_we, memwb_bubble, stall_cnt} !== {4'b1001, 4'd5}) begin n_err++; $display("FAIL to_set got=%b want=1001_0101", {timeout_err, dmem_req, pc_we, memwb_bubble, stall_cnt}); end
    $display("txn timeout: timeout_err=%b stall_cnt=%0d", timeout_err, stall_cnt);
    dmem_ready = 1'b1; ex_branch_taken = 1'b1;
    tick();
    tick();
    n_cmp++; if ({timeout_err, dmem_req, pc_we, ifid_we, ifid_flush, memwb_bubble, stall_cnt} !== {6'b100001, 4'd7}) begin n_err++; $display("FAIL err_absorb got=%b want=100001_0111", {timeout_err, dmem_req, pc_we, ifid_we, ifid_flush, memwb_bubble, stall_cnt}); end
    $display("txn err_hold: pc_we=%b dmem_req=%b", pc_we, dmem_req);
    // reset low between edges clears everything at once
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if ({timeout_err, dmem_req, pc_we, memwb_bubble, stall_cnt} !== {4'b0010, 4'd0}) begin n_err++; $display("FAIL err_async_rst got=%b want=0010_0000", {timeout_err, dmem_req, pc_we, memwb_bubble, stall_cnt}); end
    tick();
    reset = 1'b1;
    ex_branch_taken = 1'b0; dmem_ready = 1'b0;
    #1;
    n_cmp++; if ({dmem_req, pc_we} !== 2'b10) begin n_err++; $display("FAIL post_err_run got=%b want=10", {dmem_req, pc_we}); end
    $display("txn after_err_reset: dmem_req=%b pc_we=%b", dmem_req, pc_we);
    clr_inputs();
    #1;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs = 5'd12;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i > 15) ? 15 : i;
      n_cmp++; if (stall_cnt !== 4'(exp_cnt)) begin n_err++; $display("FAIL sat[%0d] got=%0d want=%0d", i, stall_cnt, exp_cnt); end
    end
    $display("txn saturation: stall_cnt=%0d", stall_cnt);
    clr_inputs();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clr_inputs();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_jump();
    test_mem_wait();
    test_wait_edges();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline; drives the write-enable and flush/bubble controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB state registers.
- Detects load-use hazards, branch/jump redirects and multi-cycle data-memory accesses (req/ready handshake).
- Freezes the pipeline on memory timeout and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MEM_TIMEOUT, 255: max WAIT cycles before timeout_err; legal 1..2^TO_W-1.
- TO_W, 8: width of the wait counter.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  branch resolved taken in EX
- id_jump  in  1  J/JAL/JR decoded in ID
- mem_access  in  1  MEM stage holds a load or store
- dmem_ready  in  1  data memory completes access this cycle
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_we  out  1  ID/EX write enable
- idex_flush  out  1  load bubble (all controls 0) into ID/EX
- exmem_we  out  1  EX/MEM write enable
- memwb_bubble  out  1  MEM/WB captures RegWrite=0
- dmem_req  out  1  data-memory request
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0
- timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- FSM states: RUN, WAIT, ERR. Reset (reset low): state=RUN, wait counter=0, stall_cnt=0, timeout_err=0.
- Outputs are combinational from state and current inputs. With reset low: pc_we, ifid_we, idex_we and exmem_we =1; flush/bubble outputs =0; dmem_req=0.
- dmem_req = mem_access when state is RUN or WAIT; 0 in ERR.
- mem_busy = mem_access & ~dmem_ready, evaluated in RUN or WAIT.
- Control priority, highest first:
  1. ERR: all we=0, memwb_bubble=1, flushes=0.
  2. mem_busy: all we=0 (whole pipeline frozen), memwb_bubble=1, flushes=0.
  3. ex_branch_taken: pc_we=1, ifid_flush=1, idex_flush=1. This overrides a simultaneous load-use stall or id_jump.
  4. load-use: condition is ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). Response: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1. Lasts exactly the one cycle the hazard holds.
  5. id_jump: ifid_flush=1, all we=1.
  6. Default: all we=1, flushes=0, memwb_bubble=0.
- FSM transitions:
  - RUN -> WAIT when mem_busy; wait counter loads 1.
  - RUN stays when mem_access & dmem_ready (zero-wait access, no stall).
  - WAIT -> RUN when dmem_ready=1; the pipeline advances in that same cycle and the counter clears.
  - WAIT stays otherwise, counter +1.
  - WAIT -> ERR when the counter equals MEM_TIMEOUT and dmem_ready=0; timeout_err is set the next edge.
  - If mem_access drops in WAIT (protocol violation): return to RUN, no error.
  - ERR is absorbing until reset.
- stall_cnt increments on every edge where pc_we=0. It saturates at all-ones and never wraps.
- Reset asserted mid-WAIT aborts the access: dmem_req drops immediately (asynchronous) and the state returns to RUN.
- $zero destination (ex_rd=0) never causes a stall.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state encoding (RUN=2'd0, WAIT=2'd1, ERR=2'd2), REG_ZERO=5'd0.
- One sub-module, load_use_detect: purely combinational hazard compare, reusable by the forwarding unit.
- FSM, counters and the output priority mux stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle only; stall_cnt 0->1.
- $zero and rt gating: ex_rd=0 or (id_rt=ex_rd with id_uses_rt=0) -> no stall, all we=1.
- Branch plus load-use together: ex_branch_taken=1 with the hazard condition active -> pc_we=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
- Memory wait: mem_access=1, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles; all we=0 for 3 cycles; state RUN after ready; stall_cnt +3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> timeout_err=1 after 5 edges; pipeline stays frozen and dmem_req=0 until reset; reset low mid-ERR clears everything asynchronously.
- Saturation: CNT_W=4, hold the load-use hazard for 20 cycles -> stall_cnt reaches 15 and stays at 15.
